// File: rtl/reg_port_arbiter_if.sv
// Shared register-file port A bundle: three requesters plus
// the registered register-file side.
interface reg_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wa_req;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wa_ack;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              RegWrite;
  logic [ADDR_W-1:0] srcA;
  logic [DATA_W-1:0] writeValue;
  logic [DATA_W-1:0] ReadA;

  modport slave (
    input  wa_req, wa_addr, wa_data,
    input  wb_req, wb_addr, wb_data,
    input  rd_req, rd_addr, ReadA,
    output wa_ack, wb_ack, rd_ack,
    output rd_data, rd_valid,
    output RegWrite, srcA, writeValue
  );

  modport master (
    output wa_req, wa_addr, wa_data,
    output wb_req, wb_addr, wb_data,
    output rd_req, rd_addr, ReadA,
    input  wa_ack, wb_ack, rd_ack,
    input  rd_data, rd_valid,
    input  RegWrite, srcA, writeValue
  );
endinterface

// File: rtl/reg_port_arbiter.sv
// Round-robin sequencer for the register file's shared A port
// (ALU writeback, load writeback, port-A read).
module reg_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic               CLK,
  input logic               RST,
  reg_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_R = 2'd2
  } sel_e;

  sel_e              last_q, last_d;
  logic              gnt_a, gnt_b, gnt_r;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] srca_q, srca_d;
  logic [DATA_W-1:0] wval_q, wval_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // priority starts just after the last grantee
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    gnt_r = 1'b0;
    if (!RST) begin
      unique case (last_q)
        SEL_A: begin
          if (bus.wb_req)      gnt_b = 1'b1;
          else if (bus.rd_req) gnt_r = 1'b1;
          else if (bus.wa_req) gnt_a = 1'b1;
        end
        SEL_B: begin
          if (bus.rd_req)      gnt_r = 1'b1;
          else if (bus.wa_req) gnt_a = 1'b1;
          else if (bus.wb_req) gnt_b = 1'b1;
        end
        default: begin
          if (bus.wa_req)      gnt_a = 1'b1;
          else if (bus.wb_req) gnt_b = 1'b1;
          else if (bus.rd_req) gnt_r = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    last_d     = last_q;
    regwrite_d = 1'b0;
    srca_d     = '0;
    wval_d     = '0;
    rd_pend_d  = 1'b0;
    unique case (1'b1)
      gnt_a: begin
        last_d     = SEL_A;
        regwrite_d = 1'b1;
        srca_d     = bus.wa_addr;
        wval_d     = bus.wa_data;
      end
      gnt_b: begin
        last_d     = SEL_B;
        regwrite_d = 1'b1;
        srca_d     = bus.wb_addr;
        wval_d     = bus.wb_data;
      end
      gnt_r: begin
        last_d    = SEL_R;
        srca_d    = bus.rd_addr;
        rd_pend_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ReadA is valid the cycle after a read issues
  always_comb begin
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_data_q;
    if (rd_pend_q) rd_data_d = bus.ReadA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q     <= SEL_R;
      regwrite_q <= 1'b0;
      srca_q     <= '0;
      wval_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      last_q     <= last_d;
      regwrite_q <= regwrite_d;
      srca_q     <= srca_d;
      wval_q     <= wval_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.wa_ack     = gnt_a;
  assign bus.wb_ack     = gnt_b;
  assign bus.rd_ack     = gnt_r;
  assign bus.RegWrite   = regwrite_q;
  assign bus.srcA       = srca_q;
  assign bus.writeValue = wval_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter with a small register
// file model hung off the port.
module tb_reg_port_arbiter;
  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } op_t;

  typedef struct {
    int who;
    int cyc;
  } gnt_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  reg_port_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  reg_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [15:0] rf [8] = '{default: 16'h0};
  always @(posedge CLK)
    if (bus.RegWrite) rf[bus.srcA] <= bus.writeValue;
  assign bus.ReadA = rf[bus.srcA];

  op_t  qa[$], qb[$], qr[$];
  op_t  wq[$], rq[$];
  gnt_t gl[$];
  int   wrc[$];
  logic [15:0] exp_rf [8] = '{default: 16'h0};
  logic [15:0] last_rd = '0;
  bit   g_a, g_b, g_r;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic present();
    bus.wa_req = qa.size() != 0;
    bus.wa_addr = '0;
    bus.wa_data = '0;
    if (qa.size() != 0) begin
      bus.wa_addr = qa[0].addr;
      bus.wa_data = qa[0].data;
    end
    bus.wb_req = qb.size() != 0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    if (qb.size() != 0) begin
      bus.wb_addr = qb[0].addr;
      bus.wb_data = qb[0].data;
    end
    bus.rd_req = qr.size() != 0;
    bus.rd_addr = '0;
    if (qr.size() != 0) bus.rd_addr = qr[0].addr;
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (g_a && qa.size() != 0) void'(qa.pop_front());
    if (g_b && qb.size() != 0) void'(qb.pop_front());
    if (g_r && qr.size() != 0) void'(qr.pop_front());
    #1 present();
  endtask

  task automatic run_idle(int budget);
    int n = 0;
    while ((qa.size() + qb.size() + qr.size() +
            wq.size() + rq.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("timeout", 32'(n < budget), 1);
    chk("sb_empty", 32'(wq.size() + rq.size()), 0);
  endtask

  task automatic chk_grants(string tag, int n, int fixed);
    chk({tag, "_n"}, 32'(gl.size()), 32'(n));
    for (int i = 0; i < gl.size(); i++) begin
      chk(tag, 32'(gl[i].who), 32'(fixed < 0 ? i % 3 : fixed));
      chk({tag, "_cyc"}, 32'(gl[i].cyc - gl[0].cyc), 32'(i));
    end
  endtask

  // scoreboard: grants push expectations, outputs pop them
  always @(negedge CLK) begin
    op_t o;
    cyc++;
    if (RST) begin
      g_a = 0;
      g_b = 0;
      g_r = 0;
      wq.delete();
      rq.delete();
    end else begin
      chk("onehot", 32'($countones(
          {bus.wa_ack, bus.wb_ack, bus.rd_ack}) <= 1), 1);
      if (bus.RegWrite) begin
        wrc.push_back(cyc);
        if (wq.size() == 0) chk("spurious_wr", 1, 0);
        else begin
          o = wq.pop_front();
          chk("wr_addr", 32'(bus.srcA), 32'(o.addr));
          chk("wr_data", 32'(bus.writeValue), 32'(o.data));
          chk("wr_lat", 32'(cyc - o.cyc), 1);
        end
      end
      if (bus.rd_valid) begin
        rd_cnt++;
        last_rd = bus.rd_data;
        if (rq.size() == 0) chk("spurious_rd", 1, 0);
        else begin
          o = rq.pop_front();
          chk("rd_data", 32'(bus.rd_data), 32'(o.data));
          chk("rd_lat", 32'(cyc - o.cyc), 2);
        end
      end
      g_a = bus.wa_ack;
      g_b = bus.wb_ack;
      g_r = bus.rd_ack;
      if (g_a) begin
        wq.push_back('{bus.wa_addr, bus.wa_data, cyc});
        exp_rf[bus.wa_addr] = bus.wa_data;
        gl.push_back('{0, cyc});
      end
      if (g_b) begin
        wq.push_back('{bus.wb_addr, bus.wb_data, cyc});
        exp_rf[bus.wb_addr] = bus.wb_data;
        gl.push_back('{1, cyc});
      end
      if (g_r) begin
        rq.push_back('{bus.rd_addr, exp_rf[bus.rd_addr], cyc});
        gl.push_back('{2, cyc});
      end
    end
  end

  initial begin
    int n0;
    RST = 1'b1;
    qa.push_back('{3'd1, 16'h1111, 0});
    qb.push_back('{3'd6, 16'h6666, 0});
    qr.push_back('{3'd1, 16'h0, 0});
    present();
    repeat (2) begin
      @(negedge CLK);
      chk("rst_ctl", 32'({bus.RegWrite, bus.srcA, bus.rd_valid,
          bus.wa_ack, bus.wb_ack, bus.rd_ack}), 0);
      chk("rst_wv", 32'(bus.writeValue), 0);
      chk("rst_rd", 32'(bus.rd_data), 0);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    run_idle(20);
    chk_grants("t1_rr", 3, -1);
    chk("t1_rd", 32'(last_rd), 32'h1111);

    gl.delete();
    qa.push_back('{3'd5, 16'h1234, 0});
    qr.push_back('{3'd5, 16'h0, 0});
    present();
    run_idle(20);
    chk("t2_rd", 32'(last_rd), 32'h1234);

    gl.delete();
    RST = 1'b1;
    qa.push_back('{3'd3, 16'h00AA, 0});
    qb.push_back('{3'd3, 16'h00BB, 0});
    qr.push_back('{3'd3, 16'h0, 0});
    present();
    repeat (2) cycle();
    chk("t3_ack_rst",
        32'({bus.wa_ack, bus.wb_ack, bus.rd_ack}), 0);
    RST = 1'b0;
    run_idle(20);
    chk_grants("t3_rr", 3, -1);
    chk("t3_rd", 32'(last_rd), 32'h00BB);

    gl.delete();
    for (int i = 0; i < 10; i++) begin
      qa.push_back('{3'($urandom_range(7)),
                     16'($urandom), 0});
      qb.push_back('{3'($urandom_range(7)),
                     16'($urandom), 0});
      qr.push_back('{3'($urandom_range(7)), 16'h0, 0});
    end
    present();
    run_idle(60);
    chk_grants("t4_rr", 30, -1);

    gl.delete();
    qr.push_back('{3'd2, 16'h0, 0});
    present();
    for (int k = 0; k < 5 && gl.size() == 0; k++) cycle();
    chk("t5_gnt", 32'(gl.size()), 1);
    chk("t5_srca", 32'(bus.srcA), 2);
    #2 RST = 1'b1;
    #1;
    chk("t5_rst_ctl", 32'({bus.RegWrite, bus.rd_valid,
        bus.srcA, bus.rd_ack}), 0);
    chk("t5_rst_rd", 32'(bus.rd_data), 0);
    repeat (2) cycle();
    RST = 1'b0;
    n0 = rd_cnt;
    repeat (4) cycle();
    chk("t5_nostrobe", 32'(rd_cnt - n0), 0);

    gl.delete();
    wrc.delete();
    for (int i = 1; i <= 4; i++)
      qb.push_back('{3'(i), 16'(i * 10), 0});
    present();
    run_idle(20);
    chk_grants("t6_b", 4, 1);
    chk("t6_wrn", 32'(wrc.size()), 4);
    for (int i = 1; i < wrc.size(); i++)
      chk("t6_wr_cyc", 32'(wrc[i] - wrc[0]), 32'(i));
    @(negedge CLK);
    chk("t6_idle", 32'({bus.RegWrite, bus.srcA}), 0);
    @(posedge CLK);
    #1;
    qr.push_back('{3'd3, 16'h0, 0});
    present();
    run_idle(20);
    chk("t6_rd", 32'(last_rd), 32'd30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
